// File: rtl/tqvp_uart_pkg.sv
// Shared constants for the buffered TinyQV UART: register offsets, STATUS bit
// positions and the TX launch FSM states.
package tqvp_uart_pkg;

  localparam logic [5:0] ADDR_DATA    = 6'h00;
  localparam logic [5:0] ADDR_STATUS  = 6'h04;
  localparam logic [5:0] ADDR_DIVIDER = 6'h08;
  localparam logic [5:0] ADDR_CTRL    = 6'h0C;

  localparam int ST_TX_BUSY   = 0;
  localparam int ST_RX_NEMPTY = 1;
  localparam int ST_TX_FULL   = 2;
  localparam int ST_RX_FULL   = 3;
  localparam int ST_TX_OVF    = 4;
  localparam int ST_RX_OVF    = 5;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_LAUNCH = 2'd1,
    TX_WAIT   = 2'd2
  } tx_state_t;

endpackage

// File: rtl/tqvp_uart_rx.sv
// 8N1 receive engine: start detected on a synchronised low, bits sampled mid-cell,
// valid held until uart_rx_read.
module tqvp_uart_rx #(
  parameter int DIVIDER_REG_LEN = 13
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       uart_rxd,
  input  logic                       uart_rx_read,
  input  logic [DIVIDER_REG_LEN-1:0] baud_divider,
  output logic                       uart_rx_valid,
  output logic [7:0]                 uart_rx_data
);

  logic [1:0]                 r_sync;
  logic                       r_active;
  logic [3:0]                 r_bits;
  logic [7:0]                 r_shift;
  logic [DIVIDER_REG_LEN-1:0] r_cnt;
  logic                       w_rxd;

  assign w_rxd = r_sync[1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sync        <= 2'b11;
      r_active      <= 1'b0;
      r_bits        <= '0;
      r_shift       <= '0;
      r_cnt         <= '0;
      uart_rx_valid <= 1'b0;
      uart_rx_data  <= '0;
    end else begin
      r_sync <= {r_sync[0], uart_rxd};
      if (uart_rx_read) uart_rx_valid <= 1'b0;
      if (!r_active) begin
        if (!w_rxd) begin
          r_active <= 1'b1;
          r_bits   <= '0;
          r_cnt    <= baud_divider >> 1;  // first sample lands mid start bit
        end
      end else if (r_cnt >= baud_divider - 1'b1) begin
        r_cnt  <= '0;
        r_bits <= r_bits + 1'b1;
        if (r_bits == 4'd0) begin
          if (w_rxd) r_active <= 1'b0;
        end else if (r_bits == 4'd9) begin
          r_active <= 1'b0;
          if (w_rxd) begin
            uart_rx_data  <= r_shift;
            uart_rx_valid <= 1'b1;
          end
        end else begin
          r_shift <= {w_rxd, r_shift[7:1]};
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tqvp_uart_sync_fifo.sv
// Single-clock FIFO with occupancy count and a combinational head; a push on a
// full FIFO is accepted only when a real pop happens in the same cycle.
module tqvp_uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count,
  output logic [WIDTH-1:0] o_head
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/tqvp_uart_tx.sv
// 8N1 transmit engine: one bit every baud_divider clocks, busy for the whole frame.
module tqvp_uart_tx #(
  parameter int DIVIDER_REG_LEN = 13
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       uart_tx_en,
  input  logic [7:0]                 uart_tx_data,
  input  logic [DIVIDER_REG_LEN-1:0] baud_divider,
  output logic                       uart_txd,
  output logic                       uart_tx_busy
);

  logic [9:0]                 r_shift;
  logic [3:0]                 r_bits;
  logic [DIVIDER_REG_LEN-1:0] r_cnt;

  assign uart_txd = r_shift[0];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_shift      <= '1;
      r_bits       <= '0;
      r_cnt        <= '0;
      uart_tx_busy <= 1'b0;
    end else if (!uart_tx_busy) begin
      if (uart_tx_en) begin
        r_shift      <= {1'b1, uart_tx_data, 1'b0};
        r_bits       <= '0;
        r_cnt        <= '0;
        uart_tx_busy <= 1'b1;
      end
    end else if (r_cnt >= baud_divider - 1'b1) begin
      // >= so a divider lowered mid-bit cannot strand the counter
      r_cnt   <= '0;
      r_shift <= {1'b1, r_shift[9:1]};
      r_bits  <= r_bits + 1'b1;
      if (r_bits == 4'd9) uart_tx_busy <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tqvp_uart_fifo.sv
// Buffered UART for the TinyQV peripheral slot: TX/RX FIFOs, threshold IRQs,
// sticky overflow flags, RTS. Optional loopback via TQVP_UART_LOOPBACK_EN.
module tqvp_uart_fifo import tqvp_uart_pkg::*; #(
  parameter int DIVIDER_REG_LEN = 13,
  parameter int CLOCK_MHZ       = 64,
  parameter int TX_DEPTH        = 8,
  parameter int RX_DEPTH        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic [1:0]  user_interrupt
);

  localparam int TXCW = $clog2(TX_DEPTH) + 1;
  localparam int RXCW = $clog2(RX_DEPTH) + 1;
  localparam logic [DIVIDER_REG_LEN-1:0] DIV_RESET =
    DIVIDER_REG_LEN'(CLOCK_MHZ * 1000000 / 115200);

  logic [DIVIDER_REG_LEN-1:0] r_divider;
  logic                       r_rxd_sel, r_tx_ovf, r_rx_ovf;
  logic [7:0]                 r_rx_thresh, r_tx_thresh;
  tx_state_t                  r_tx_state, w_tx_next;

  logic            w_wr, w_rd, w_wr_byte, w_tx_push, w_rx_pop, w_tx_en;
  logic            w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [TXCW-1:0] w_tx_count;
  logic [RXCW-1:0] w_rx_count;
  logic [7:0]      w_tx_head, w_rx_head, w_rx_data, w_rx_th;
  logic            w_txd, w_txd_pin, w_rxd, w_tx_busy, w_rx_valid, w_loop_bit;
  logic [31:0]     w_status;
  logic            w_unused;

  assign w_wr      = (data_write_n != 2'b11);
  assign w_rd      = (data_read_n != 2'b11);
  assign w_wr_byte = (data_write_n == 2'b00);
  assign w_tx_push = w_wr && (address == ADDR_DATA);
  assign w_rx_pop  = w_rd && (address == ADDR_DATA);
  assign w_unused  = &{1'b0, ui_in[6:4], ui_in[2:0], data_in[31:24]};

`ifdef TQVP_UART_LOOPBACK_EN
  logic r_loopback;
  assign w_loop_bit = r_loopback;
  assign w_rxd      = r_loopback ? w_txd : (r_rxd_sel ? ui_in[3] : ui_in[7]);
  assign w_txd_pin  = w_txd | r_loopback;
`else
  assign w_loop_bit = 1'b0;
  assign w_rxd      = r_rxd_sel ? ui_in[3] : ui_in[7];
  assign w_txd_pin  = w_txd;
`endif

  assign uo_out     = {4{w_rx_full, w_txd_pin}};
  assign data_ready = 1'b1;

  tqvp_uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .i_push(w_tx_push), .i_data(data_in[7:0]), .i_pop(w_tx_en),
    .o_full(w_tx_full), .o_empty(w_tx_empty), .o_count(w_tx_count), .o_head(w_tx_head)
  );

  tqvp_uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .i_push(w_rx_valid), .i_data(w_rx_data), .i_pop(w_rx_pop),
    .o_full(w_rx_full), .o_empty(w_rx_empty), .o_count(w_rx_count), .o_head(w_rx_head)
  );

  tqvp_uart_tx #(.DIVIDER_REG_LEN(DIVIDER_REG_LEN)) u_tx (
    .clk(clk), .resetn(~rst), .uart_tx_en(w_tx_en), .uart_tx_data(w_tx_head),
    .baud_divider(r_divider), .uart_txd(w_txd), .uart_tx_busy(w_tx_busy)
  );

  tqvp_uart_rx #(.DIVIDER_REG_LEN(DIVIDER_REG_LEN)) u_rx (
    .clk(clk), .resetn(~rst), .uart_rxd(w_rxd), .uart_rx_read(1'b1),
    .baud_divider(r_divider), .uart_rx_valid(w_rx_valid), .uart_rx_data(w_rx_data)
  );

  // LAUNCH gives the engine one cycle to raise busy before WAIT samples it
  always_ff @(posedge clk) begin
    if (rst) r_tx_state <= TX_IDLE;
    else     r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_en   = 1'b0;
    case (r_tx_state)
      TX_IDLE: if (!w_tx_empty && !w_tx_busy) begin
        w_tx_en   = 1'b1;
        w_tx_next = TX_LAUNCH;
      end
      TX_LAUNCH: w_tx_next = TX_WAIT;
      TX_WAIT:   if (!w_tx_busy) w_tx_next = TX_IDLE;
      default:   w_tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_divider   <= DIV_RESET;
      r_rxd_sel   <= 1'b0;
      r_rx_thresh <= 8'd1;
      r_tx_thresh <= 8'd0;
      r_tx_ovf    <= 1'b0;
      r_rx_ovf    <= 1'b0;
    end else begin
      if (w_wr && address == ADDR_DIVIDER) begin
        if (w_wr_byte) r_divider[7:0] <= data_in[7:0];
        else           r_divider      <= data_in[DIVIDER_REG_LEN-1:0];
      end
      if (w_wr && address == ADDR_CTRL) begin
        r_rxd_sel <= data_in[0];
        if (!w_wr_byte)               r_rx_thresh <= data_in[15:8];
        if (data_write_n == 2'b10)    r_tx_thresh <= data_in[23:16];
      end
      if (w_wr && address == ADDR_STATUS) begin
        if (data_in[ST_TX_OVF]) r_tx_ovf <= 1'b0;
        if (data_in[ST_RX_OVF]) r_rx_ovf <= 1'b0;
      end
      // a new drop in the same cycle as a clear wins
      if (w_tx_push && w_tx_full && !w_tx_en) r_tx_ovf <= 1'b1;
      if (w_rx_valid && w_rx_full && !w_rx_pop) r_rx_ovf <= 1'b1;
    end
  end

`ifdef TQVP_UART_LOOPBACK_EN
  always_ff @(posedge clk) begin
    if (rst) r_loopback <= 1'b0;
    else if (w_wr && address == ADDR_CTRL) r_loopback <= data_in[1];
  end
`endif

  always_comb begin
    w_status                = '0;
    w_status[ST_TX_BUSY]    = w_tx_busy | ~w_tx_empty;
    w_status[ST_RX_NEMPTY]  = ~w_rx_empty;
    w_status[ST_TX_FULL]    = w_tx_full;
    w_status[ST_RX_FULL]    = w_rx_full;
    w_status[ST_TX_OVF]     = r_tx_ovf;
    w_status[ST_RX_OVF]     = r_rx_ovf;
    w_status[15:8]          = 8'(w_rx_count);
    w_status[23:16]         = 8'(w_tx_count);
  end

  always_comb begin
    data_out = '0;
    case (address)
      ADDR_DATA:    data_out = w_rx_empty ? 32'd0 : {24'd0, w_rx_head};
      ADDR_STATUS:  data_out = w_status;
      ADDR_DIVIDER: data_out = 32'(r_divider);
      ADDR_CTRL:    data_out = {8'd0, r_tx_thresh, r_rx_thresh, 6'd0, w_loop_bit, r_rxd_sel};
      default:      data_out = '0;
    endcase
  end

  assign w_rx_th           = (r_rx_thresh == 8'd0) ? 8'd1 : r_rx_thresh;
  assign user_interrupt[0] = (8'(w_rx_count) >= w_rx_th);
  assign user_interrupt[1] = (8'(w_tx_count) <= r_tx_thresh);

endmodule

// File: tb/tb_tqvp_uart_fifo.sv
// Directed bench for tqvp_uart_fifo: register map, TX framing, overflow, RX fill,
// IRQ thresholds, reset mid-frame; loopback when TQVP_UART_LOOPBACK_EN is set.
module tb_tqvp_uart_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ui_in = 8'hFF;
  logic [7:0]  uo_out;
  logic [5:0]  address = 6'h0;
  logic [31:0] data_in = 32'h0;
  logic [1:0]  data_write_n = 2'b11;
  logic [1:0]  data_read_n = 2'b11;
  logic [31:0] data_out;
  logic        data_ready;
  logic [1:0]  user_interrupt;

  int total = 0;
  int bad   = 0;

  tqvp_uart_fifo #(.DIVIDER_REG_LEN(13), .CLOCK_MHZ(64), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out), .address(address),
    .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(data_out), .data_ready(data_ready), .user_interrupt(user_interrupt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] w);
    @(negedge clk);
    address = a; data_in = d; data_write_n = w;
    @(posedge clk); #1;
    data_write_n = 2'b11;
  endtask

  task automatic peek(input logic [5:0] a, output logic [31:0] v);
    @(negedge clk);
    address = a;
    #1 v = data_out;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] v);
    @(negedge clk);
    address = a; data_read_n = 2'b10;
    #1 v = data_out;
    @(posedge clk); #1;
    data_read_n = 2'b11;
  endtask

  // drive one 8N1 frame at 16 clocks per bit onto ui_in[pin]
  task automatic send_frame(input logic [7:0] b, input int pin);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ui_in[pin] = f[i];
      repeat (15) @(negedge clk);
    end
  endtask

  // decode one frame from uo_out[0], divider 16; ok=0 on timeout or framing error
  task automatic get_frame(output logic [7:0] b, output logic ok);
    int n;
    n = 0; ok = 1'b1; b = 8'h00;
    while (uo_out[0] !== 1'b0) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin ok = 1'b0; return; end
    end
    repeat (8) @(negedge clk);
    if (uo_out[0] !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(negedge clk);
      b[i] = uo_out[0];
    end
    repeat (16) @(negedge clk);
    if (uo_out[0] !== 1'b1) ok = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  b;
    logic        ok;
    int          n, lows;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    peek(6'h04, v); check("rst_status", v, 32'h0);
    peek(6'h08, v); check("rst_divider", v, 32'd555);
    peek(6'h0C, v); check("rst_ctrl", v, 32'h0000_0100);
    check("rst_uo_out", {24'd0, uo_out}, 32'h55);
    check("rst_irq", {30'd0, user_interrupt}, 32'h2);
    check("data_ready", {31'd0, data_ready}, 32'h1);
    peek(6'h10, v); check("unmapped_read", v, 32'h0);

    // divider: byte write keeps upper bits, word write replaces all
    wr(6'h08, 32'h0000_1234, 2'b00);
    peek(6'h08, v); check("div_byte", v, 32'h0000_0234);
    wr(6'h08, 32'd16, 2'b10);
    peek(6'h08, v); check("div_word", v, 32'd16);

    // three back-to-back TX frames; first byte launches before the third push
    wr(6'h00, 32'h41, 2'b00);
    wr(6'h00, 32'h42, 2'b00);
    wr(6'h00, 32'h43, 2'b00);
    peek(6'h04, v); check("tx3_status", v, 32'h0002_0001);
    check("tx3_irq", {30'd0, user_interrupt}, 32'h0);
    get_frame(b, ok); check("tx_f0_ok", {31'd0, ok}, 32'h1); check("tx_f0", {24'd0, b}, 32'h41);
    get_frame(b, ok); check("tx_f1_ok", {31'd0, ok}, 32'h1); check("tx_f1", {24'd0, b}, 32'h42);
    check("tx_irq_pending", {30'd0, user_interrupt}, 32'h0);
    get_frame(b, ok); check("tx_f2_ok", {31'd0, ok}, 32'h1); check("tx_f2", {24'd0, b}, 32'h43);
    check("tx_irq_drained", {30'd0, user_interrupt}, 32'h2);
    repeat (20) @(negedge clk);
    peek(6'h04, v); check("tx_done_status", v, 32'h0);

    // TX overflow with the engine held on a very slow frame
    wr(6'h08, 32'h1FFF, 2'b10);
    wr(6'h00, 32'hFF, 2'b00);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 9; i++) wr(6'h00, 32'h10 + i, 2'b00);
    peek(6'h04, v); check("txovf_status", v, 32'h0008_0015);
    wr(6'h04, 32'h10, 2'b10);
    peek(6'h04, v); check("txovf_clear", v, 32'h0008_0005);
    wr(6'h08, 32'd16, 2'b01);
    n = 0;
    peek(6'h04, v);
    while (v[23:16] != 8'd7 && n < 2000) begin peek(6'h04, v); n++; end
    check("txovf_launch_timeout", {31'd0, (n < 2000)}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      get_frame(b, ok);
      check("txovf_frame_ok", {31'd0, ok}, 32'h1);
      check("txovf_frame", {24'd0, b}, 32'h10 + i);
    end
    lows = 0;
    repeat (300) begin @(negedge clk); if (uo_out[0] !== 1'b1) lows++; end
    check("txovf_ninth_not_sent", lows, 0);
    peek(6'h04, v); check("txovf_idle_status", v, 32'h0);

    // RX fill past depth without reads
    for (int i = 0; i < 10; i++) send_frame(8'h30 + 8'(i), 7);
    repeat (4) @(negedge clk);
    peek(6'h04, v); check("rxfull_status", v, 32'h0000_082A);
    check("rxfull_uo_out", {24'd0, uo_out}, 32'hFF);
    check("rxfull_irq", {30'd0, user_interrupt}, 32'h3);
    for (int i = 0; i < 8; i++) begin
      rd(6'h00, v); check("rx_read", v, 32'h30 + i);
    end
    peek(6'h04, v); check("rx_drained_status", v, 32'h20);
    rd(6'h00, v); check("rx_empty_read", v, 32'h0);
    wr(6'h04, 32'h20, 2'b10);
    peek(6'h04, v); check("rxovf_clear", v, 32'h0);
    check("rx_drained_uo_out", {24'd0, uo_out}, 32'h55);

    // RX threshold 4
    wr(6'h0C, 32'h0000_0400, 2'b01);
    peek(6'h0C, v); check("ctrl_half", v, 32'h0000_0400);
    for (int i = 0; i < 3; i++) send_frame(8'hA1 + 8'(i), 7);
    repeat (4) @(negedge clk);
    check("rxth_3", {30'd0, user_interrupt}, 32'h2);
    send_frame(8'hA4, 7);
    repeat (4) @(negedge clk);
    check("rxth_4", {30'd0, user_interrupt}, 32'h3);
    rd(6'h00, v); check("rxth_read", v, 32'hA1);
    check("rxth_after_read", {30'd0, user_interrupt}, 32'h2);
    for (int i = 0; i < 3; i++) begin rd(6'h00, v); check("rxth_drain", v, 32'hA2 + i); end

    // alternate RXD pin; byte write leaves RX_THRESH alone
    wr(6'h0C, 32'h0000_FF01, 2'b00);
    peek(6'h0C, v); check("ctrl_byte", v, 32'h0000_0401);
    send_frame(8'hC3, 3);
    repeat (4) @(negedge clk);
    peek(6'h04, v); check("rxsel_status", v, 32'h0000_0102);
    rd(6'h00, v); check("rxsel_read", v, 32'hC3);

`ifdef TQVP_UART_LOOPBACK_EN
    wr(6'h0C, 32'h0000_0002, 2'b10);
    peek(6'h0C, v); check("ctrl_loop", v, 32'h0000_0002);
    wr(6'h00, 32'h5A, 2'b00);
    lows = 0;
    repeat (200) begin @(negedge clk); if (uo_out[0] !== 1'b1) lows++; end
    check("loop_txd_high", lows, 0);
    rd(6'h00, v); check("loop_read", v, 32'h5A);
`else
    wr(6'h0C, 32'h0000_0002, 2'b10);
    peek(6'h0C, v); check("ctrl_noloop", v, 32'h0);
`endif
    wr(6'h0C, 32'h0000_0100, 2'b10);

    // reset mid-frame
    wr(6'h00, 32'h11, 2'b00);
    wr(6'h00, 32'h22, 2'b00);
    repeat (40) @(negedge clk);
    peek(6'h04, v); check("midframe_status", v, 32'h0001_0001);
    check("midframe_txd_low", {31'd0, uo_out[0]}, 32'h0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_uo_out", {24'd0, uo_out}, 32'h55);
    @(negedge clk); rst = 1'b0;
    peek(6'h04, v); check("rst_mid_status", v, 32'h0);
    peek(6'h08, v); check("rst_mid_divider", v, 32'd555);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
